// File: rtl/c5_ifetch_if.sv
// Signal bundle between the instruction-fetch stage, the PC block, memory and decode.
// master is the fetch unit; slave is everything around it.
interface c5_ifetch_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:2]      I_pc_future;
    logic             I_pause_in;
    logic             O_pause_out;
    logic             O_mem_req;
    logic [31:2]      O_mem_addr;
    logic             I_mem_ack;
    logic [WIDTH-1:0] I_mem_rdata;
    logic [31:0]      O_opcode;
    logic             O_opcode_valid;
    logic             O_fetch_err;

    modport master (
        input  I_pc_future, I_pause_in, I_mem_ack, I_mem_rdata,
        output O_pause_out, O_mem_req, O_mem_addr, O_opcode, O_opcode_valid, O_fetch_err
    );

    modport slave (
        output I_pc_future, I_pause_in, I_mem_ack, I_mem_rdata,
        input  O_pause_out, O_mem_req, O_mem_addr, O_opcode, O_opcode_valid, O_fetch_err
    );
endinterface

// File: rtl/c5_ifetch.sv
// Instruction-fetch stage: req/ack read of the opcode at the future PC, with a pause-hold
// state and a bus watchdog that substitutes a NOP and raises a sticky error flag.
module c5_ifetch #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic         I_clk,
    input logic         I_rst,
    c5_ifetch_if.master bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [31:2]       mem_addr_q, mem_addr_d;
    logic [31:0]       opcode_q, opcode_d;
    logic              opcode_valid_q, opcode_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              wd_hit;
    logic              done;

    // Ack has priority: the watchdog only counts as a hit when no ack is present.
    assign wd_hit = (state_q == StFetch) && !bus.I_mem_ack && (count_q == CntW'(TIMEOUT - 1));
    assign done   = (state_q == StFetch) && (bus.I_mem_ack || wd_hit);

    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        opcode_d       = opcode_q;
        opcode_valid_d = opcode_valid_q;
        fetch_err_d    = fetch_err_q;
        count_d        = count_q;

        unique case (state_q)
            StIdle: begin
                mem_addr_d = bus.I_pc_future;
                mem_req_d  = 1'b1;
                count_d    = '0;
                state_d    = StFetch;
            end
            StFetch: begin
                if (!done) begin
                    count_d        = count_q + CntW'(1);
                    opcode_valid_d = 1'b0;
                end else begin
                    if (bus.I_mem_ack) begin
                        opcode_d = 32'(bus.I_mem_rdata[WIDTH-1:0]);
                    end else begin
                        opcode_d    = '0;
                        fetch_err_d = 1'b1;
                    end
                    opcode_valid_d = 1'b1;
                    if (!bus.I_pause_in) begin
                        mem_addr_d = bus.I_pc_future;
                        mem_req_d  = 1'b1;
                        count_d    = '0;
                        state_d    = StFetch;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (!bus.I_pause_in) begin
                    mem_addr_d = bus.I_pc_future;
                    mem_req_d  = 1'b1;
                    count_d    = '0;
                    state_d    = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q        <= StIdle;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            opcode_q       <= '0;
            opcode_valid_q <= 1'b0;
            fetch_err_q    <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
            fetch_err_q    <= fetch_err_d;
            count_q        <= count_d;
        end
    end

    assign bus.O_pause_out    = (state_q == StIdle) || ((state_q == StFetch) && !done);
    assign bus.O_mem_req      = mem_req_q;
    assign bus.O_mem_addr     = mem_addr_q;
    assign bus.O_opcode       = opcode_q;
    assign bus.O_opcode_valid = opcode_valid_q;
    assign bus.O_fetch_err    = fetch_err_q;
endmodule

// File: tb/tb_c5_ifetch.sv
// Self-checking bench for c5_ifetch: returned opcodes go through a scoreboard queue,
// control outputs are checked directly against constants.
module tb_c5_ifetch;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q[$];

    c5_ifetch_if #(.WIDTH(32)) bus ();

    c5_ifetch #(
        .WIDTH   (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got opcode %h expected none queued", tag, bus.O_opcode);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.O_opcode, e);
            check({tag, "_valid"}, 32'(bus.O_opcode_valid), 32'd1);
        end
    endtask

    // Advance one clock; sample point is the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.I_pc_future = '0;
        bus.I_pause_in  = 1'b0;
        bus.I_mem_ack   = 1'b0;
        bus.I_mem_rdata = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_req",   32'(bus.O_mem_req), 32'd0);
        check("rst_addr",  32'(bus.O_mem_addr), 32'd0);
        check("rst_op",    bus.O_opcode, 32'd0);
        check("rst_valid", 32'(bus.O_opcode_valid), 32'd0);
        check("rst_err",   32'(bus.O_fetch_err), 32'd0);
        check("rst_pause", 32'(bus.O_pause_out), 32'd1);

        // Zero-wait memory, pc 0,1,2
        rst = 1'b0;
        cycle();
        check("launch_req", 32'(bus.O_mem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("zw_addr", 32'(bus.O_mem_addr), 32'(i));
            check("zw_req", 32'(bus.O_mem_req), 32'd1);
            bus.I_pc_future = 30'(i + 1);
            bus.I_mem_ack   = 1'b1;
            bus.I_mem_rdata = 32'h1000 + 32'(i);
            exp_q.push_back(32'h1000 + 32'(i));
            #1;
            check("zw_pause", 32'(bus.O_pause_out), 32'd0);
            cycle();
            pop_check("zw_op");
        end

        // Ack delayed three cycles
        bus.I_mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("dly_pause", 32'(bus.O_pause_out), 32'd1);
            check("dly_addr", 32'(bus.O_mem_addr), 32'd3);
            cycle();
        end
        check("dly_valid_low", 32'(bus.O_opcode_valid), 32'd0);
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = 32'h24020005;
        bus.I_pc_future = 30'd10;
        exp_q.push_back(32'h24020005);
        #1;
        check("dly_pause_ack", 32'(bus.O_pause_out), 32'd0);
        cycle();
        pop_check("dly_op");
        check("dly_next_addr", 32'(bus.O_mem_addr), 32'd10);

        // Ack while paused, then hold; stray acks in HOLD must be ignored
        bus.I_pause_in  = 1'b1;
        bus.I_mem_rdata = 32'hABCD0001;
        exp_q.push_back(32'hABCD0001);
        cycle();
        bus.I_mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check("hold_req", 32'(bus.O_mem_req), 32'd0);
            check("hold_op", bus.O_opcode, 32'hABCD0001);
            check("hold_valid", 32'(bus.O_opcode_valid), 32'd1);
            check("hold_pause", 32'(bus.O_pause_out), 32'd0);
            if (k < 3) cycle();
        end
        pop_check("pause_op");
        bus.I_mem_ack   = 1'b0;
        bus.I_pause_in  = 1'b0;
        bus.I_pc_future = 30'd20;
        cycle();
        check("relaunch_req", 32'(bus.O_mem_req), 32'd1);
        check("relaunch_addr", 32'(bus.O_mem_addr), 32'd20);

        // Watchdog: no ack at all
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            #1;
            check("wd_pause", 32'(bus.O_pause_out), (k < int'(TIMEOUT) - 1) ? 32'd1 : 32'd0);
            if (k == int'(TIMEOUT) - 1) exp_q.push_back(32'd0);
            cycle();
        end
        pop_check("wd_op");
        check("wd_err", 32'(bus.O_fetch_err), 32'd1);
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = 32'h00000055;
        exp_q.push_back(32'h00000055);
        cycle();
        pop_check("post_wd_op");
        check("err_sticky", 32'(bus.O_fetch_err), 32'd1);

        // Reset mid-fetch between edges; late ack across release must be ignored
        bus.I_mem_ack   = 1'b0;
        bus.I_pc_future = 30'd40;
        cycle();
        #2;
        rst = 1'b1;
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = 32'hBAD0BAD0;
        #1;
        check("amid_req", 32'(bus.O_mem_req), 32'd0);
        check("amid_valid", 32'(bus.O_opcode_valid), 32'd0);
        check("amid_op", bus.O_opcode, 32'd0);
        check("amid_err", 32'(bus.O_fetch_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("rel_req", 32'(bus.O_mem_req), 32'd1);
        check("rel_addr", 32'(bus.O_mem_addr), 32'd40);
        check("rel_op", bus.O_opcode, 32'd0);
        check("rel_valid", 32'(bus.O_opcode_valid), 32'd0);

        // Ack exactly on the watchdog cycle: data wins, no error
        bus.I_mem_ack = 1'b0;
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) cycle();
        bus.I_mem_ack   = 1'b1;
        bus.I_mem_rdata = 32'h00000077;
        exp_q.push_back(32'h00000077);
        #1;
        check("edge_pause", 32'(bus.O_pause_out), 32'd0);
        cycle();
        pop_check("edge_op");
        check("edge_err", 32'(bus.O_fetch_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
